// File: rtl/lcm_pkg.sv
// Shared constants and state type for the LCM engine.
package lcm_pkg;

    localparam int unsigned LCM_WIDTH = 32;

    typedef enum logic [2:0] {
        StIdle,
        StGcd,
        StDiv,
        StMul,
        StDone
    } lcm_state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle, MSB first, fixed WIDTH-cycle latency.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] quotient_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // divisor_i is read every iteration, so the caller holds it stable while busy_o is high
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            cnt_q <= CntW'(WIDTH);
        end else if (cnt_q != '0) begin
            if (!trial[WIDTH]) begin
                rem_q <= trial[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= shifted[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign busy_o     = (cnt_q != '0);
    assign quotient_o = quo_q;

endmodule

// File: rtl/lcm_fsm.sv
// LCM engine: subtractive-Euclid GCD, then lcm = (a / gcd) * b via sequential divide and multiply.
module lcm_fsm
    import lcm_pkg::*;
#(
    parameter int unsigned WIDTH = LCM_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] lcm,
    output logic               done,
    output logic               busy
);

    localparam int unsigned CntW = $clog2(WIDTH);

    lcm_state_t         state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   y_q;
    logic [WIDTH-1:0]   g_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [CntW-1:0]    cnt_q;
    logic               div_start;
    logic               div_busy;
    logic [WIDTH-1:0]   div_quo;

    // Divider loads on the GCD equality edge so its WIDTH iterations line up with the DIV cycles
    assign div_start = (state_q == StGcd) && (x_q == y_q);

    seq_divider #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk_i      (clk),
        .rst_i      (reset),
        .start_i    (div_start),
        .dividend_i (a_q),
        .divisor_i  (g_q),
        .busy_o     (div_busy),
        .quotient_o (div_quo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            g_q     <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            lcm     <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q  <= a;
                        b_q  <= b;
                        x_q  <= a;
                        y_q  <= b;
                        busy <= 1'b1;
                        if (a == '0 || b == '0) begin
                            acc_q   <= '0;
                            state_q <= StDone;
                        end else begin
                            state_q <= StGcd;
                        end
                    end
                end
                StGcd: begin
                    if (x_q == y_q) begin
                        g_q     <= x_q;
                        cnt_q   <= '0;
                        state_q <= StDiv;
                    end else if (x_q > y_q) begin
                        x_q <= x_q - y_q;
                    end else begin
                        y_q <= y_q - x_q;
                    end
                end
                StDiv: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1) && div_busy) begin
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        mcand_q <= {{WIDTH{1'b0}}, b_q};
                        state_q <= StMul;
                    end
                end
                StMul: begin
                    // Quotient is final and stable here; walk its bits LSB first
                    if (div_quo[cnt_q]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q <= {mcand_q[2*WIDTH-2:0], 1'b0};
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    lcm     <= acc_q;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcm_fsm.sv
// Self-checking bench for lcm_fsm: directed cases plus random operands against an arithmetic model.
module tb_lcm_fsm;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] lcm;
    logic           done;
    logic           busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lcm_fsm #(
        .WIDTH(W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .lcm   (lcm),
        .done  (done),
        .busy  (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // lcm from gcd arithmetic; latency from the subtractive-Euclid step count
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  output logic [63:0] ml, output int lat);
        longint unsigned x;
        longint unsigned y;
        int n;
        if (ma == 0 || mb == 0) begin
            ml  = 64'd0;
            lat = 1;
            return;
        end
        x = 64'(ma);
        y = 64'(mb);
        n = 0;
        while (x != y) begin
            n++;
            if (x > y) x -= y;
            else y -= x;
        end
        n++;
        ml  = (64'(ma) / x) * 64'(mb);
        lat = n + 2 * W + 1;
    endfunction

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input string tag);
        logic [63:0] el;
        int lat;
        int k;
        model(ta, tb_v, el, lat);
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " busy_after_e0"}, 64'(busy), 64'd1);
        k = 0;
        // Scramble inputs and poke start while busy; none of it may disturb the result
        while (done !== 1'b1 && k < lat + 8) begin
            start = (k < lat - 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            a     = $urandom;
            b     = $urandom;
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        check({tag, " done_seen"}, 64'(done), 64'd1);
        check({tag, " latency"}, 64'(k), 64'(lat));
        check({tag, " lcm"}, lcm, el);
        @(posedge clk);
        #1;
        check({tag, " done_drop"}, 64'(done), 64'd0);
        check({tag, " busy_drop"}, 64'(busy), 64'd0);
        check({tag, " lcm_hold"}, lcm, el);
    endtask

    initial begin
        int pulses;
        int dk;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_lcm", lcm, 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(32'd48, 32'd18, "ex48_18");
        run_op(32'd0, 32'd5, "zero_a");
        run_op(32'd9, 32'd0, "zero_b");
        run_op(32'd7, 32'd7, "equal7");
        run_op(32'h8000_0000, 32'hC000_0000, "upper_word");

        // Abort in flight with reset; no done may appear from the aborted operation
        @(negedge clk);
        a     = 32'd48;
        b     = 32'd18;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        pulses = 0;
        repeat (39) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_lcm", lcm, 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);
        run_op(32'd21, 32'd6, "after_abort");

        // Second start pulse at E0+10 is ignored
        @(negedge clk);
        a     = 32'd48;
        b     = 32'd18;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        pulses = 0;
        dk     = 0;
        for (int k = 1; k <= 90; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                pulses++;
                dk = k;
            end
            if (k == 9) begin
                start = 1'b1;
                a     = 32'd5;
                b     = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        check("ignore_pulses", 64'(pulses), 64'd1);
        check("ignore_latency", 64'(dk), 64'd70);
        check("ignore_lcm", lcm, 64'd144);

        for (int i = 0; i < 8; i++) begin
            ra = 32'($urandom_range(1, 3000));
            rb = 32'($urandom_range(1, 3000));
            run_op(ra, rb, "rand_small");
        end
        for (int i = 0; i < 4; i++) begin
            ra = 32'($urandom_range(1, 200)) << 23;
            rb = 32'($urandom_range(1, 200)) << 23;
            run_op(ra, rb, "rand_large");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
